// File: rtl/ycr_serial_debug_mlane.sv
// ---------------------------------------------------------------------------
// ycr_serial_debug_mlane
//
// Multi-lane serializer for the core's internal debug bus. A DEBUG_WD-bit
// snapshot of debug_bus is split into LANES slices of SLICE_WD bits. Each
// slice is shifted out LSB-first on its own pin. A sync marks bit 0 of every
// frame, a strobe marks the first clk of every bit period, and the bit period
// is cfg_div+1 clks. Frames run back-to-back in continuous mode, or once per
// trig in one-shot mode.
//
// Build option:
//   YCR_SDBG_PARITY_EN - append one even-parity bit per lane, so a frame is
//                        SLICE_WD+1 bits long. Without it, frames are SLICE_WD
//                        bits and no parity logic is built.
//
// Ports:
//   clk                in   core clock
//   reset              in   asynchronous, active-high reset
//   cfg_enable         in   serializer enable
//   cfg_oneshot        in   1: capture only on trig, 0: continuous frames
//   cfg_div            in   bit period = cfg_div+1 clks, latched at frame load
//   trig               in   one-cycle capture request (one-shot mode)
//   debug_bus          in   vector to serialize
//   serial_debug_data  out  lane k carries debug_bus[k*SLICE_WD +: SLICE_WD]
//   serial_debug_sync  out  high during bit 0 of each frame
//   serial_debug_strb  out  one-cycle pulse on the first clk of every bit
//   frame_done         out  one-cycle pulse on the last clk of a frame
// ---------------------------------------------------------------------------
module ycr_serial_debug_mlane #(
  parameter int unsigned DEBUG_WD = 64,
  parameter int unsigned LANES    = 4,
  parameter int unsigned DIV_WD   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_enable,
  input  logic                cfg_oneshot,
  input  logic [DIV_WD-1:0]   cfg_div,
  input  logic                trig,
  input  logic [DEBUG_WD-1:0] debug_bus,
  output logic [LANES-1:0]    serial_debug_data,
  output logic                serial_debug_sync,
  output logic                serial_debug_strb,
  output logic                frame_done
);

  localparam int unsigned SLICE_WD = DEBUG_WD / LANES;
`ifdef YCR_SDBG_PARITY_EN
  localparam int unsigned FRAME_LEN = SLICE_WD + 1;
`else
  localparam int unsigned FRAME_LEN = SLICE_WD;
`endif
  localparam int unsigned CNT_WD = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_WD-1:0] LAST_BIT = CNT_WD'(FRAME_LEN - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e                          state_q;
  logic [LANES-1:0][FRAME_LEN-1:0] shreg_q;
  logic [CNT_WD-1:0]               bit_cnt_q;
  logic [DIV_WD-1:0]               div_cnt_q;
  logic [DIV_WD-1:0]               div_lat_q;
  logic                            sync_q;
  logic                            strb_q;
  logic                            trig_pend_q;

  logic                            start;
  logic                            tick;
  logic                            last_bit;
  logic                            load;
  logic [LANES-1:0][FRAME_LEN-1:0] load_val;

  // Per-lane frame image captured at load; the parity bit (when built) sits
  // above the slice so it is shifted out last.
  always_comb begin
    load_val = '0;
    for (int k = 0; k < LANES; k++) begin
`ifdef YCR_SDBG_PARITY_EN
      load_val[k] = {^debug_bus[k*SLICE_WD +: SLICE_WD], debug_bus[k*SLICE_WD +: SLICE_WD]};
`else
      load_val[k] = debug_bus[k*SLICE_WD +: SLICE_WD];
`endif
    end
  end

  assign start    = cfg_enable & (~cfg_oneshot | trig_pend_q);
  assign tick     = (state_q == StShift) && (div_cnt_q == div_lat_q);
  assign last_bit = tick && (bit_cnt_q == LAST_BIT);
  // Reloading on the final tick is what makes continuous frames gapless.
  assign load     = start && ((state_q == StIdle) || last_bit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      div_lat_q   <= '0;
      sync_q      <= 1'b0;
      strb_q      <= 1'b0;
      trig_pend_q <= 1'b0;
    end else begin
      // A trig coinciding with a load re-arms for the next frame.
      if (load) begin
        trig_pend_q <= trig & cfg_enable;
      end else if (trig & cfg_enable) begin
        trig_pend_q <= 1'b1;
      end

      if (load) begin
        state_q   <= StShift;
        shreg_q   <= load_val;
        bit_cnt_q <= '0;
        div_cnt_q <= '0;
        div_lat_q <= cfg_div;
        sync_q    <= 1'b1;
        strb_q    <= 1'b1;
      end else if (state_q == StShift) begin
        if (tick) begin
          div_cnt_q <= '0;
          if (last_bit) begin
            // Clearing the shifter forces the data pins low while idle.
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sync_q    <= 1'b0;
            strb_q    <= 1'b0;
          end else begin
            for (int k = 0; k < LANES; k++) begin
              shreg_q[k] <= {1'b0, shreg_q[k][FRAME_LEN-1:1]};
            end
            bit_cnt_q <= bit_cnt_q + 1'b1;
            sync_q    <= 1'b0;
            strb_q    <= 1'b1;
          end
        end else begin
          div_cnt_q <= div_cnt_q + 1'b1;
          strb_q    <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    serial_debug_data = '0;
    for (int k = 0; k < LANES; k++) begin
      serial_debug_data[k] = shreg_q[k][0];
    end
  end

  assign serial_debug_sync = sync_q;
  assign serial_debug_strb = strb_q;
  assign frame_done        = last_bit;

endmodule

// File: tb/tb_ycr_serial_debug_mlane.sv
// Scoreboard bench for ycr_serial_debug_mlane. A frame-level model pushes the
// expected bit sequence when a frame should start; a monitor pops one entry per
// strobe and checks data, sync, hold length and frame_done.
module tb_ycr_serial_debug_mlane;

  localparam int unsigned DEBUG_WD = 64;
  localparam int unsigned LANES    = 4;
  localparam int unsigned DIV_WD   = 8;
  localparam int unsigned SLICE_WD = DEBUG_WD / LANES;
`ifdef YCR_SDBG_PARITY_EN
  localparam int unsigned FRAME_LEN = SLICE_WD + 1;
`else
  localparam int unsigned FRAME_LEN = SLICE_WD;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                cfg_enable;
  logic                cfg_oneshot;
  logic [DIV_WD-1:0]   cfg_div;
  logic                trig;
  logic [DEBUG_WD-1:0] debug_bus;
  logic [LANES-1:0]    serial_debug_data;
  logic                serial_debug_sync;
  logic                serial_debug_strb;
  logic                frame_done;

  ycr_serial_debug_mlane #(
    .DEBUG_WD (DEBUG_WD),
    .LANES    (LANES),
    .DIV_WD   (DIV_WD)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .cfg_enable        (cfg_enable),
    .cfg_oneshot       (cfg_oneshot),
    .cfg_div           (cfg_div),
    .trig              (trig),
    .debug_bus         (debug_bus),
    .serial_debug_data (serial_debug_data),
    .serial_debug_sync (serial_debug_sync),
    .serial_debug_strb (serial_debug_strb),
    .frame_done        (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0] data;
    bit               sync;
    int               hold;
    bit               last;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Frame-level reference: a frame occupies FRAME_LEN*(div+1) clks and a new
  // one starts whenever start holds and no frame is running (or on its last clk).
  bit                m_busy = 0;
  int                m_rem  = 0;
  bit                m_pend = 0;
  bit                m_start;
  bit                m_last;
  bit                m_load;
  exp_t              m_e;
  logic [SLICE_WD-1:0] m_sl;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_busy = 0;
        m_rem  = 0;
        m_pend = 0;
        q.delete();
      end else begin
        m_start = cfg_enable && (!cfg_oneshot || m_pend);
        m_last  = m_busy && (m_rem == 1);
        m_load  = m_start && (!m_busy || m_last);
        if (m_busy) begin
          m_rem--;
          if (m_rem == 0) m_busy = 0;
        end
        if (m_load) m_pend = trig && cfg_enable;
        else if (trig && cfg_enable) m_pend = 1;
        if (m_load) begin
          m_busy = 1;
          m_rem  = FRAME_LEN * (int'(cfg_div) + 1);
          for (int b = 0; b < FRAME_LEN; b++) begin
            for (int k = 0; k < LANES; k++) begin
              m_sl = debug_bus[k*SLICE_WD +: SLICE_WD];
              m_e.data[k] = (b < SLICE_WD) ? m_sl[b] : ^m_sl;
            end
            m_e.sync = (b == 0);
            m_e.hold = int'(cfg_div) + 1;
            m_e.last = (b == FRAME_LEN - 1);
            q.push_back(m_e);
          end
        end
      end
    end
  end

  // Monitor: samples on the falling edge, away from input changes.
  exp_t cur;
  bit   have_cur = 0;
  int   cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset || !m_busy) begin
        have_cur = 0;
        chk("idle_data", 64'(serial_debug_data), 64'd0);
        chk("idle_sync", 64'(serial_debug_sync), 64'd0);
        chk("idle_strb", 64'(serial_debug_strb), 64'd0);
        chk("idle_frame_done", 64'(frame_done), 64'd0);
      end else begin
        if (serial_debug_strb) begin
          if (have_cur) chk("hold_len", 64'(cnt), 64'(cur.hold));
          if (q.size() == 0) begin
            chk("strb_without_expected_bit", 64'd1, 64'd0);
            have_cur = 0;
          end else begin
            cur = q.pop_front();
            have_cur = 1;
            cnt = 1;
            chk("bit_data", 64'(serial_debug_data), 64'(cur.data));
            chk("bit_sync", 64'(serial_debug_sync), 64'(cur.sync));
          end
        end else if (have_cur) begin
          cnt++;
          chk("hold_data", 64'(serial_debug_data), 64'(cur.data));
          chk("hold_sync", 64'(serial_debug_sync), 64'(cur.sync));
          chk("hold_overrun", 64'(cnt > cur.hold), 64'd0);
        end else begin
          chk("first_strb", 64'(serial_debug_strb), 64'd1);
        end
        chk("frame_done", 64'(frame_done), 64'(have_cur && cur.last && cnt == cur.hold));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    cfg_enable  = 1'b0;
    cfg_oneshot = 1'b0;
    cfg_div     = '0;
    trig        = 1'b0;
    debug_bus   = '0;
    cyc(3);
    @(negedge clk);
    chk("reset_data", 64'(serial_debug_data), 64'd0);
    chk("reset_sync", 64'(serial_debug_sync), 64'd0);
    chk("reset_strb", 64'(serial_debug_strb), 64'd0);
    chk("reset_frame_done", 64'(frame_done), 64'd0);
    cyc(1);
    reset = 1'b0;

    // Continuous, one bit per clk, fixed pattern.
    debug_bus  = 64'h0123_4567_89AB_CDEF;
    cfg_enable = 1'b1;
    cyc(3 * FRAME_LEN + 5);

    // Four clks per bit; bus wanders, cfg_div changes mid-frame.
    cfg_div = 8'd3;
    for (int i = 0; i < 150; i++) begin
      debug_bus = {$urandom, $urandom};
      if (i == 70) cfg_div = 8'($urandom_range(0, 5));
      cyc(1);
    end

    // Drop enable part-way through a frame.
    cfg_div = 8'd0;
    cyc(FRAME_LEN + 5);
    cfg_enable = 1'b0;
    cyc(100);

    // One-shot: single trig, trig mid-frame, trig while disabled.
    cfg_oneshot = 1'b1;
    cfg_div     = 8'd1;
    cfg_enable  = 1'b1;
    debug_bus   = {$urandom, $urandom};
    cyc(5);
    trig = 1'b1; cyc(1); trig = 1'b0;
    cyc(10);
    trig = 1'b1; cyc(1); trig = 1'b0;
    cyc(4 * FRAME_LEN + 10);
    cfg_enable = 1'b0;
    trig = 1'b1; cyc(1); trig = 1'b0;
    cyc(3);
    cfg_enable = 1'b1;
    cyc(2 * FRAME_LEN + 10);

    // Reset around bit 7 with three clks per bit, then restart.
    cfg_oneshot = 1'b0;
    cfg_div     = 8'd2;
    debug_bus   = {$urandom, $urandom};
    cyc(7 * 3 + 2);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(3 * FRAME_LEN + 4);

    // Parity-sensitive slices: lane0 = 0007, lane1 = 0003.
    cfg_enable = 1'b0;
    cyc(3 * FRAME_LEN + 4);
    cfg_div   = 8'd0;
    debug_bus = {16'($urandom), 16'($urandom), 16'h0003, 16'h0007};
    cfg_oneshot = 1'b1;
    cfg_enable  = 1'b1;
    trig = 1'b1; cyc(1); trig = 1'b0;
    cyc(FRAME_LEN + 6);

    // Randomised control.
    for (int i = 0; i < 600; i++) begin
      debug_bus = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 15) == 0) cfg_oneshot = ~cfg_oneshot;
      if ($urandom_range(0, 19) == 0) cfg_div = 8'($urandom_range(0, 3));
      trig  = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 249) == 0);
      cyc(1);
    end
    trig       = 1'b0;
    reset      = 1'b0;
    cfg_enable = 1'b0;
    cyc(120);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
